// File: rtl/lsq_dcache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsq_dcache_arbiter
// Purpose  : Shares the single data-cache port between the load-queue head
//            and the committed store-queue head. Loads have priority, but
//            a waiting store is guaranteed service after MAX_LOAD_STREAK
//            consecutive load completions. When the store queue is full,
//            the store goes first.
//            The selected request is registered onto the dc_* outputs and
//            held until the cache reports no miss. Then a one-cycle grant
//            goes back to the owning queue.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   ld_req_valid/addr/id: load-queue head request
//   ld_grant            : load completed in cache (one-cycle pulse)
//   st_req_valid/addr/data, st_queue_full : committed store-queue head
//   st_grant            : store completed in cache (one-cycle pulse)
//   branch_miss         : misprediction flush
//   dc_valid, dc_mem_action, dc_addr, dc_data, dc_id : cache request
//   dc_miss             : cache stall, the request must be held
// Optional build macro
//   LSQ_ARB_PERF_EN     : adds perf_ld_cnt, perf_st_cnt, perf_stall_cnt
// ============================================================================
module lsq_dcache_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 6,
    parameter int MAX_LOAD_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [ID_W-1:0]   ld_req_id,
    output logic              ld_grant,
    input  logic              st_req_valid,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    input  logic              st_queue_full,
    output logic              st_grant,
    input  logic              branch_miss,
    output logic              dc_valid,
    output logic              dc_mem_action,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_data,
    output logic [ID_W-1:0]   dc_id,
    input  logic              dc_miss
`ifdef LSQ_ARB_PERF_EN
    ,
    output logic [31:0]       perf_ld_cnt,
    output logic [31:0]       perf_st_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [3:0] c_streak_max = 4'(MAX_LOAD_STREAK);

    state_e              state_q,         state_d;
    logic                dc_valid_q,      dc_valid_d;
    logic                dc_mem_action_q, dc_mem_action_d;
    logic [ADDR_W-1:0]   dc_addr_q,       dc_addr_d;
    logic [DATA_W-1:0]   dc_data_q,       dc_data_d;
    logic [ID_W-1:0]     dc_id_q,         dc_id_d;
    logic [3:0]          streak_q,        streak_d;
    logic                squash_q,        squash_d;

    logic                w_sel_st;
    logic                w_sel_ld;
    logic                w_complete;
    logic                w_ld_grant;
    logic                w_st_grant;

    // Store wins if it is forced (queue full or load streak exhausted), or
    // if no load is competing. A flush blocks only load selection because
    // stores at the queue head are already committed.
    assign w_sel_st = st_req_valid &&
                      (st_queue_full || (streak_q >= c_streak_max) || !ld_req_valid);
    assign w_sel_ld = !w_sel_st && ld_req_valid && !branch_miss;

    assign w_complete = (state_q == BUSY) && !dc_miss;
    assign w_ld_grant = w_complete && dc_mem_action_q && !squash_q;
    assign w_st_grant = w_complete && !dc_mem_action_q;

    always_comb begin
        state_d         = state_q;
        dc_valid_d      = dc_valid_q;
        dc_mem_action_d = dc_mem_action_q;
        dc_addr_d       = dc_addr_q;
        dc_data_d       = dc_data_q;
        dc_id_d         = dc_id_q;
        squash_d        = squash_q;

        case (state_q)
            IDLE: begin
                if (w_sel_st) begin
                    state_d         = BUSY;
                    dc_valid_d      = 1'b1;
                    dc_mem_action_d = 1'b0;
                    dc_addr_d       = st_req_addr;
                    dc_data_d       = st_req_data;
                    dc_id_d         = '0;
                    squash_d        = 1'b0;
                end else if (w_sel_ld) begin
                    state_d         = BUSY;
                    dc_valid_d      = 1'b1;
                    dc_mem_action_d = 1'b1;
                    dc_addr_d       = ld_req_addr;
                    dc_data_d       = '0;
                    dc_id_d         = ld_req_id;
                    squash_d        = 1'b0;
                end
            end
            BUSY: begin
                // A refill cannot be aborted, so a flushed load keeps
                // running and only its grant is dropped.
                if (branch_miss && dc_mem_action_q) begin
                    squash_d = 1'b1;
                end
                // Returning to IDLE gives a one-cycle bubble so the
                // granted queue head can advance before the next arbitration.
                if (!dc_miss) begin
                    state_d    = IDLE;
                    dc_valid_d = 1'b0;
                    squash_d   = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                dc_valid_d = 1'b0;
                squash_d   = 1'b0;
            end
        endcase
    end

    // Count consecutive load completions only while a store is actually
    // waiting; any cycle without a store pending restarts the count.
    always_comb begin
        streak_d = streak_q;
        if (!st_req_valid || w_st_grant) begin
            streak_d = '0;
        end else if (w_ld_grant && (streak_q < c_streak_max)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            dc_valid_q      <= 1'b0;
            dc_mem_action_q <= 1'b0;
            dc_addr_q       <= '0;
            dc_data_q       <= '0;
            dc_id_q         <= '0;
            streak_q        <= '0;
            squash_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            dc_valid_q      <= dc_valid_d;
            dc_mem_action_q <= dc_mem_action_d;
            dc_addr_q       <= dc_addr_d;
            dc_data_q       <= dc_data_d;
            dc_id_q         <= dc_id_d;
            streak_q        <= streak_d;
            squash_q        <= squash_d;
        end
    end

    assign dc_valid      = dc_valid_q;
    assign dc_mem_action = dc_mem_action_q;
    assign dc_addr       = dc_addr_q;
    assign dc_data       = dc_data_q;
    assign dc_id         = dc_id_q;
    assign ld_grant      = w_ld_grant;
    assign st_grant      = w_st_grant;

`ifdef LSQ_ARB_PERF_EN
    logic [31:0] perf_ld_cnt_q,    perf_ld_cnt_d;
    logic [31:0] perf_st_cnt_q,    perf_st_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    // The counters wrap naturally at 2^32.
    always_comb begin
        perf_ld_cnt_d    = perf_ld_cnt_q    + {31'd0, w_ld_grant};
        perf_st_cnt_d    = perf_st_cnt_q    + {31'd0, w_st_grant};
        perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, (state_q == BUSY) && dc_miss};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ld_cnt_q    <= '0;
            perf_st_cnt_q    <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_ld_cnt_q    <= perf_ld_cnt_d;
            perf_st_cnt_q    <= perf_st_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign perf_ld_cnt    = perf_ld_cnt_q;
    assign perf_st_cnt    = perf_st_cnt_q;
    assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsq_dcache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsq_dcache_arbiter
// Purpose  : Directed, table-driven checks of lsq_dcache_arbiter, plus
//            sequences for load-streak fairness and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsq_dcache_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ld_req_valid;
    logic [31:0] ld_req_addr;
    logic [5:0]  ld_req_id;
    logic        ld_grant;
    logic        st_req_valid;
    logic [31:0] st_req_addr;
    logic [31:0] st_req_data;
    logic        st_queue_full;
    logic        st_grant;
    logic        branch_miss;
    logic        dc_valid;
    logic        dc_mem_action;
    logic [31:0] dc_addr;
    logic [31:0] dc_data;
    logic [5:0]  dc_id;
    logic        dc_miss;
`ifdef LSQ_ARB_PERF_EN
    logic [31:0] perf_ld_cnt;
    logic [31:0] perf_st_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    lsq_dcache_arbiter #(
        .ADDR_W          (32),
        .DATA_W          (32),
        .ID_W            (6),
        .MAX_LOAD_STREAK (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_req_valid  (ld_req_valid),
        .ld_req_addr   (ld_req_addr),
        .ld_req_id     (ld_req_id),
        .ld_grant      (ld_grant),
        .st_req_valid  (st_req_valid),
        .st_req_addr   (st_req_addr),
        .st_req_data   (st_req_data),
        .st_queue_full (st_queue_full),
        .st_grant      (st_grant),
        .branch_miss   (branch_miss),
        .dc_valid      (dc_valid),
        .dc_mem_action (dc_mem_action),
        .dc_addr       (dc_addr),
        .dc_data       (dc_data),
        .dc_id         (dc_id),
        .dc_miss       (dc_miss)
`ifdef LSQ_ARB_PERF_EN
        ,
        .perf_ld_cnt   (perf_ld_cnt),
        .perf_st_cnt   (perf_st_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld_v;
        logic [31:0] ld_addr;
        logic [5:0]  ld_id;
        logic        st_v;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        full;
        logic        bm;
        logic        miss;
        logic        e_valid;
        logic        e_act;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [5:0]  e_id;
        logic        e_lg;
        logic        e_sg;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic lv, input logic [31:0] la, input logic [5:0] li,
        input logic sv, input logic [31:0] sa, input logic [31:0] sd,
        input logic f, input logic b, input logic m,
        input logic ev, input logic ea, input logic [31:0] eaddr,
        input logic [31:0] edata, input logic [5:0] eid,
        input logic elg, input logic esg);
        vec_t r;
        r.ld_v = lv; r.ld_addr = la; r.ld_id = li;
        r.st_v = sv; r.st_addr = sa; r.st_data = sd;
        r.full = f; r.bm = b; r.miss = m;
        r.e_valid = ev; r.e_act = ea; r.e_addr = eaddr;
        r.e_data = edata; r.e_id = eid; r.e_lg = elg; r.e_sg = esg;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [31:0] la, input logic [5:0] li,
                         input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic f, input logic b, input logic m);
        ld_req_valid = lv; ld_req_addr = la; ld_req_id = li;
        st_req_valid = sv; st_req_addr = sa; st_req_data = sd;
        st_queue_full = f; branch_miss = b; dc_miss = m;
    endtask

    // Payload is compared only while a request is expected on the port.
    function automatic logic [127:0] obs_pack(input logic v, input logic lg, input logic sg,
                                              input logic a, input logic [31:0] ad,
                                              input logic [31:0] d, input logic [5:0] id);
        obs_pack = {54'd0, v, lg, sg, (v ? {a, ad, d, id} : 71'd0)};
    endfunction

    initial begin
        logic exp_lg;
        logic exp_sg;

        // idle / single load
        vecs[0]  = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        vecs[1]  = mk(1,'h100,5,   0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        vecs[2]  = mk(1,'h100,5,   0,0,0,                  0,0,0, 1,1,'h100,0,5, 1,0);
        vecs[3]  = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        // store held through three miss cycles
        vecs[4]  = mk(0,0,0,       1,'h200,'hDEADBEEF,     0,0,0, 0,0,0,0,0, 0,0);
        vecs[5]  = mk(0,0,0,       1,'h200,'hDEADBEEF,     0,0,1, 1,0,'h200,'hDEADBEEF,0, 0,0);
        vecs[6]  = mk(0,0,0,       1,'h200,'hDEADBEEF,     0,0,1, 1,0,'h200,'hDEADBEEF,0, 0,0);
        vecs[7]  = mk(0,0,0,       1,'h200,'hDEADBEEF,     0,0,1, 1,0,'h200,'hDEADBEEF,0, 0,0);
        vecs[8]  = mk(0,0,0,       1,'h200,'hDEADBEEF,     0,0,0, 1,0,'h200,'hDEADBEEF,0, 0,1);
        vecs[9]  = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        // full store queue beats a competing load
        vecs[10] = mk(1,'h300,7,   1,'h400,'h11223344,     1,0,0, 0,0,0,0,0, 0,0);
        vecs[11] = mk(1,'h300,7,   1,'h400,'h11223344,     1,0,0, 1,0,'h400,'h11223344,0, 0,1);
        vecs[12] = mk(1,'h300,7,   0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        vecs[13] = mk(1,'h300,7,   0,0,0,                  0,0,0, 1,1,'h300,0,7, 1,0);
        vecs[14] = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        // branch_miss: blocks in IDLE, squashes in BUSY
        vecs[15] = mk(1,'h500,9,   0,0,0,                  0,1,0, 0,0,0,0,0, 0,0);
        vecs[16] = mk(1,'h500,9,   0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        vecs[17] = mk(1,'h500,9,   0,0,0,                  0,1,1, 1,1,'h500,0,9, 0,0);
        vecs[18] = mk(0,0,0,       0,0,0,                  0,0,1, 1,1,'h500,0,9, 0,0);
        vecs[19] = mk(0,0,0,       0,0,0,                  0,0,0, 1,1,'h500,0,9, 0,0);
        vecs[20] = mk(1,'h600,3,   0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        vecs[21] = mk(1,'h600,3,   0,0,0,                  0,0,0, 1,1,'h600,0,3, 1,0);
        vecs[22] = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        // simultaneous, not full, streak 0: load wins, then store
        vecs[23] = mk(1,'h700,1,   1,'h800,'hA5A5A5A5,     0,0,0, 0,0,0,0,0, 0,0);
        vecs[24] = mk(1,'h700,1,   1,'h800,'hA5A5A5A5,     0,0,0, 1,1,'h700,0,1, 1,0);
        vecs[25] = mk(0,0,0,       1,'h800,'hA5A5A5A5,     0,0,0, 0,0,0,0,0, 0,0);
        vecs[26] = mk(0,0,0,       1,'h800,'hA5A5A5A5,     0,0,0, 1,0,'h800,'hA5A5A5A5,0, 0,1);
        vecs[27] = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        // request dropped right after selection is still captured
        vecs[28] = mk(1,'h900,2,   0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);
        vecs[29] = mk(0,0,0,       0,0,0,                  0,0,0, 1,1,'h900,0,2, 1,0);
        vecs[30] = mk(0,0,0,       0,0,0,                  0,0,0, 0,0,0,0,0, 0,0);

        rst_n = 1'b0;
        drive(0,0,0, 0,0,0, 0,0,0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {54'd0, dc_valid, ld_grant, st_grant, dc_mem_action, dc_addr, dc_data, dc_id}, 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].ld_v, vecs[i].ld_addr, vecs[i].ld_id,
                  vecs[i].st_v, vecs[i].st_addr, vecs[i].st_data,
                  vecs[i].full, vecs[i].bm, vecs[i].miss);
            #1;
            chk($sformatf("vec%0d", i),
                obs_pack(dc_valid, ld_grant, st_grant, dc_mem_action, dc_addr, dc_data, dc_id),
                obs_pack(vecs[i].e_valid, vecs[i].e_lg, vecs[i].e_sg, vecs[i].e_act,
                         vecs[i].e_addr, vecs[i].e_data, vecs[i].e_id));
        end

        // Both requesters held: grants every other cycle, order L,L,L,L,S x2.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            drive(1,'hA0,11, 1,'hB0,'h55AA55AA, 0,0,0);
            #1;
            exp_lg = 1'b0;
            exp_sg = 1'b0;
            if (k % 2 == 1) begin
                if (((k - 1) / 2) % 5 == 4) exp_sg = 1'b1;
                else                        exp_lg = 1'b1;
            end
            chk($sformatf("streak_cyc%0d", k), {126'd0, ld_grant, st_grant}, {126'd0, exp_lg, exp_sg});
        end
        @(negedge clk);
        drive(0,0,0, 0,0,0, 0,0,0);

        // Asynchronous reset while a load is stalled.
        @(negedge clk);
        drive(1,'hA00,4, 0,0,0, 0,0,1);
        @(negedge clk);
        #1;
        chk("pre_reset_busy", {126'd0, dc_valid, ld_grant}, {126'd0, 1'b1, 1'b0});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_now", {125'd0, dc_valid, ld_grant, st_grant}, 128'd0);
        @(negedge clk);
        drive(0,0,0, 0,0,0, 0,0,0);
        #1;
        chk("reset_held", {54'd0, dc_valid, ld_grant, st_grant, dc_mem_action, dc_addr, dc_data, dc_id}, 128'd0);
        rst_n = 1'b1;

        @(negedge clk);
        drive(1,'hB00,6, 0,0,0, 0,0,0);
        #1;
        chk("post_reset_n", obs_pack(dc_valid, ld_grant, st_grant, dc_mem_action, dc_addr, dc_data, dc_id),
                            obs_pack(0,0,0,0,0,0,0));
        @(negedge clk);
        #1;
        chk("post_reset_n1", obs_pack(dc_valid, ld_grant, st_grant, dc_mem_action, dc_addr, dc_data, dc_id),
                             obs_pack(1,1,0,1,'hB00,0,6));
        @(negedge clk);
        drive(0,0,0, 0,0,0, 0,0,0);
        #1;
        chk("post_reset_idle", {126'd0, dc_valid, ld_grant}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
